// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, fetches one word per instruction over req/ack
// and presents the decoded fields until execute retires the instruction.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [3:0]  o_cond,
  output logic [1:0]  o_op,
  output logic [5:0]  o_funct,
  output logic [3:0]  o_rn,
  output logic [3:0]  o_rd,
  output logic [31:0] o_pc_plus8,
  input  logic        i_exec_done,
  input  logic        i_pc_src,
  input  logic [31:0] i_pc_target,
  output logic        o_fetch_err,
  output logic [1:0]  o_err_code
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ISSUE,
    S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [7:0]  r_cnt;
  logic [1:0]  r_err_code;
  logic        w_timeout;
  logic        w_bad_tgt;

  assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));
  assign w_bad_tgt = (i_pc_target[1:0] != 2'b00);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  w_next = S_REQ;
      S_REQ: begin
        if (i_imem_ack)     w_next = S_ISSUE;
        else if (w_timeout) w_next = S_ERR;
      end
      S_ISSUE: begin
        if (i_exec_done) begin
          if (i_pc_src && w_bad_tgt) w_next = S_ERR;
          else                       w_next = S_REQ;
        end
      end
      S_ERR:   w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Counter is cleared on every path into REQ.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc       <= RESET_PC;
      r_instr    <= 32'h0;
      r_cnt      <= 8'h0;
      r_err_code <= 2'b00;
    end else begin
      unique case (r_state)
        S_IDLE: r_cnt <= 8'h0;
        S_REQ: begin
          if (i_imem_ack)     r_instr    <= i_imem_rdata;
          else if (w_timeout) r_err_code <= 2'b01;
          else                r_cnt      <= r_cnt + 8'h1;
        end
        S_ISSUE: begin
          if (i_exec_done) begin
            if (!i_pc_src) begin
              r_pc  <= r_pc + 32'd4;
              r_cnt <= 8'h0;
            end else if (!w_bad_tgt) begin
              r_pc  <= i_pc_target;
              r_cnt <= 8'h0;
            end else begin
              r_err_code <= 2'b10;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_imem_req    = (r_state == S_REQ);
  assign o_imem_addr   = r_pc;
  assign o_instr_valid = (r_state == S_ISSUE);
  assign o_fetch_err   = (r_state == S_ERR);
  assign o_err_code    = r_err_code;
  assign o_instr       = r_instr;
  assign o_cond        = r_instr[31:28];
  assign o_op          = r_instr[27:26];
  assign o_funct       = r_instr[25:20];
  assign o_rn          = r_instr[19:16];
  assign o_rd          = r_instr[15:12];
  assign o_pc_plus8    = r_pc + 32'd8;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: stimulus pushes expected
// fetches, a monitor pops them when instr_valid rises.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rn;
  logic [3:0]  rd;
  logic [31:0] pc_plus8;
  logic        exec_done;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        fetch_err;
  logic [1:0]  err_code;

  instruction_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .TIMEOUT (16)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_ack   (imem_ack),
    .i_imem_rdata (imem_rdata),
    .o_instr_valid(instr_valid),
    .o_instr      (instr),
    .o_cond       (cond),
    .o_op         (op),
    .o_funct      (funct),
    .o_rn         (rn),
    .o_rd         (rd),
    .o_pc_plus8   (pc_plus8),
    .i_exec_done  (exec_done),
    .i_pc_src     (pc_src),
    .i_pc_target  (pc_target),
    .o_fetch_err  (fetch_err),
    .o_err_code   (err_code)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (instr_valid && !prev) begin
        if (q.size() == 0) begin
          chk("unexpected_issue", 32'(instr_valid), 32'h0);
        end else begin
          e = q.pop_front();
          chk("instr", instr, e.word);
          chk("cond", 32'(cond), 32'(e.word[31:28]));
          chk("op", 32'(op), 32'(e.word[27:26]));
          chk("funct", 32'(funct), 32'(e.word[25:20]));
          chk("rn", 32'(rn), 32'(e.word[19:16]));
          chk("rd", 32'(rd), 32'(e.word[15:12]));
          chk("pc_plus8", pc_plus8, e.addr + 32'd8);
          chk("issue_err", 32'(fetch_err), 32'h0);
        end
      end
      prev = instr_valid;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_err", 32'(fetch_err), 32'h0);
    chk("rst_code", 32'(err_code), 32'h0);
    chk("rst_pc", imem_addr, 32'h0);
    rst = 1'b0;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) chk("req_wait_timeout", 32'(imem_req), 32'h1);
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] word,
                       input int waits, input bit noise);
    exp_t e;
    wait_req();
    chk("imem_addr", imem_addr, addr);
    for (int i = 0; i < waits; i++) begin
      if (noise) begin
        exec_done = 1'b1;
        pc_src    = 1'b1;
        pc_target = 32'h42;
      end
      @(negedge clk);
      exec_done = 1'b0;
      pc_src    = 1'b0;
      chk("req_held", 32'(imem_req), 32'h1);
      chk("addr_held", imem_addr, addr);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    e.addr = addr;
    e.word = word;
    q.push_back(e);
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
  endtask

  task automatic retire(input logic src, input logic [31:0] tgt);
    int n;
    n = 0;
    while (!instr_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) chk("valid_wait_timeout", 32'(instr_valid), 32'h1);
    exec_done = 1'b1;
    pc_src    = src;
    pc_target = tgt;
    @(negedge clk);
    exec_done = 1'b0;
    pc_src    = 1'b0;
    pc_target = 32'h0;
  endtask

  initial begin : stim
    int n;
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    exec_done  = 1'b0;
    pc_src     = 1'b0;
    pc_target  = 32'h0;
    do_reset();

    fetch(32'h0, 32'hE081_2003, 0, 1'b0);
    chk("valid_after_ack", 32'(instr_valid), 32'h1);
    chk("req_in_issue", 32'(imem_req), 32'h0);
    retire(1'b0, 32'h0);
    fetch(32'h4, 32'h1234_5678, 2, 1'b0);
    retire(1'b0, 32'h0);
    fetch(32'h8, 32'hA5C3_F00F, 0, 1'b0);
    retire(1'b0, 32'h0);
    fetch(32'hC, 32'h0F0F_0F0F, 1, 1'b1);
    retire(1'b0, 32'h0);
    fetch(32'h10, 32'h5A5A_1234, 15, 1'b0);
    chk("late_ack_err", 32'(fetch_err), 32'h0);
    retire(1'b1, 32'h40);
    fetch(32'h40, 32'hC3C3_9876, 0, 1'b0);
    retire(1'b1, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h7654_3210, 0, 1'b0);
    retire(1'b0, 32'h0);
    fetch(32'h0, 32'h9ABC_DEF0, 0, 1'b0);
    chk("wrap_err", 32'(fetch_err), 32'h0);

    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk("ack_ignored", instr, 32'h9ABC_DEF0);

    retire(1'b1, 32'h42);
    chk("mis_err", 32'(fetch_err), 32'h1);
    chk("mis_code", 32'(err_code), 32'h2);
    chk("mis_req", 32'(imem_req), 32'h0);
    chk("mis_valid", 32'(instr_valid), 32'h0);
    chk("mis_pc", imem_addr, 32'h0);
    repeat (4) @(negedge clk);
    imem_ack  = 1'b1;
    exec_done = 1'b1;
    @(negedge clk);
    imem_ack  = 1'b0;
    exec_done = 1'b0;
    chk("err_sticky", 32'(fetch_err), 32'h1);
    chk("err_req", 32'(imem_req), 32'h0);
    chk("err_code_held", 32'(err_code), 32'h2);

    do_reset();
    wait_req();
    n = 0;
    while (imem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", 32'(n), 32'd16);
    chk("to_err", 32'(fetch_err), 32'h1);
    chk("to_code", 32'(err_code), 32'h1);
    chk("to_valid", 32'(instr_valid), 32'h0);

    do_reset();
    wait_req();
    rst = 1'b1;
    #1;
    chk("rst_mid_req", 32'(imem_req), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    fetch(32'h0, 32'h1111_2222, 1, 1'b0);
    retire(1'b0, 32'h0);
    fetch(32'h4, 32'h3333_4444, 0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_mid_issue", 32'(instr_valid), 32'h0);
    chk("rst_mid_instr", instr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_req();
    chk("restart_pc", imem_addr, 32'h0);

    repeat (2) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
